imem_uart_loader: RTL
=====================

Name: imem_uart_loader

Overview:
- Writer side of the instruction memory: receives a program image over a UART line and writes it word by word into imem through that memory's write port (in/we/addr).
- Holds the processor core in reset while loading.
- Releases the core from reset only after a complete, checksum-verified image has been written.
- Sits between the board RX pin and the imem write port; the core keeps the read port.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (8N1, LSB first); must be >= 4.
- ADDR_WIDTH, 12, imem word address width (4096 words).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rxd  input  1  UART serial input, asynchronous, idle high
- mem_we  output  1  imem write enable, one-cycle pulse per word
- mem_addr  output  ADDR_WIDTH  imem word address
- mem_wdata  output  32  imem write data
- cpu_rst  output  1  processor reset request, high while not loaded
- done  output  1  image loaded and verified
- err  output  1  last load attempt failed

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0. State=HDR, receiver idle.
- Reset mid-load discards all progress; words already written stay in imem.
- rxd passes through a 2-FF synchronizer before any use.
- Receiver start detection: a synchronized high->low transition starts a frame.
- Receiver start bit: start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the frame is treated as a glitch and dropped silently.
- Receiver data/stop sampling: data bits are sampled every CLKS_PER_BIT after that; the stop bit is sampled likewise.
- Receiver stop bit low: framing error, byte discarded, loader FSM goes to ERR.
- Receiver good byte: byte_valid pulses one cycle after the stop-bit sample.
- Packet format, in order:
  - header 0xA5;
  - length L, 16 bits, little-endian, counted in words;
  - L*4 data bytes, each word little-endian;
  - checksum byte = 8-bit modular sum of the data bytes only.
- FSM states: HDR, LEN0, LEN1, DATA, SUM, DONE, ERR.
- HDR: 0xA5 -> LEN0; any other byte is ignored.
- LEN0: latch L[7:0] -> LEN1.
- LEN1: latch L[15:8].
  - L > 2**ADDR_WIDTH -> ERR.
  - L==0 -> SUM.
  - Otherwise -> DATA with word index=0 and sum=0.
- DATA: shift bytes into a 32-bit assembler and add each to sum.
  - On the 4th byte of a word: the next cycle drives mem_we=1 for exactly one cycle, with mem_addr=word index and mem_wdata=assembled word.
  - The index then increments.
  - After word L-1 -> SUM.
- SUM: received byte == sum -> DONE, else -> ERR.
- DONE: done=1, cpu_rst=0 from the cycle after the checksum byte_valid.
- ERR: err=1, done=0, cpu_rst=1.
- Entering ERR from any state, including framing errors in DONE: same outputs as ERR.
- Reload: in DONE or ERR, a received 0xA5 clears done/err, sets cpu_rst=1 in the next cycle, and goes to LEN0.
- Non-header bytes in DONE/ERR are ignored.
- mem_addr/mem_wdata hold their last values when mem_we=0. mem_we is never asserted outside DATA.
- mem_addr arithmetic is ADDR_WIDTH bits wide. L == 2**ADDR_WIDTH is legal: the last word is written at the maximum address and no wrap write occurs.
- No timeout: a stalled transfer waits indefinitely with cpu_rst=1.

Test Plan (bench uses CLKS_PER_BIT=4, ADDR_WIDTH=12):
- Good image: send A5 02 00 78 56 34 12 EF BE AD DE 4C -> we pulses (addr 0, 0x12345678) then (addr 1, 0xDEADBEEF). done=1 and cpu_rst=0 one cycle after the last byte_valid. err=0.
- Bad checksum: same image with 4D as last byte -> both words written, err=1, done=0, cpu_rst=1.
- Noise before header: send 00 FF 13, then the good image -> extra bytes ignored, identical writes, done=1.
- Framing / glitch:
  - stop bit forced 0 during the 5th data byte -> err=1, no second write;
  - separately, a rxd low pulse of 1 clk while idle -> no byte, no state change.
- Length bounds:
  - A5 00 00 00 -> done=1, no we pulse;
  - A5 01 10 -> err=1 right after the LEN1 byte, no we.
- Reload and reset:
  - after DONE, send A5 -> cpu_rst=1, done=0 next cycle;
  - then assert rst for 1 cycle mid-DATA -> all outputs return to reset values, FSM waits for a header.

Source files
------------

// File: rtl/imem_uart_loader_if.sv
// imem write port as seen by the loader (master) and the instruction memory (slave).
// Purely combinational wiring; no latency, no backpressure on the write port.
interface imem_uart_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (output mem_we, mem_addr, mem_wdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// UART (8N1) boot loader: writes a checksummed image into imem, holding the core in reset until it verifies.
// One write pulse the cycle after each word's 4th byte; no backpressure -- imem must accept every write.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxd,
  imem_uart_loader_if.master  mem,
  output logic                cpu_rst,
  output logic                done,
  output logic                err
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]    MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {HDR, LEN0, LEN1, DATA, SUM, DONE, ERR} ld_state_t;

  rx_state_t       rx_state, rx_state_n;
  logic            rxd_meta, rxd_sync, rxd_prev;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_shift;
  logic            byte_vld, frame_err;
  logic            tick;

  ld_state_t         state, state_n;
  logic [7:0]        len_lo;
  logic [15:0]       len_full;
  logic [15:0]       words_left;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]        byte_cnt;
  logic [31:0]       asm_word;
  logic [7:0]        sum;
  logic              word_end;

  // Start bit is checked at its midpoint; every later sample is one full bit further on.
  assign tick = (rx_state == RX_START) ? (clk_cnt == HALF_LAST) : (clk_cnt == BIT_LAST);

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  if (rxd_prev && !rxd_sync) rx_state_n = RX_START;
      RX_START: if (tick) rx_state_n = rxd_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) rx_state_n = RX_STOP;
      RX_STOP:  if (tick) rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      rx_state  <= RX_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxd_meta  <= rxd;
      rxd_sync  <= rxd_meta;
      rxd_prev  <= rxd_sync;
      rx_state  <= rx_state_n;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      clk_cnt   <= (rx_state == RX_IDLE || tick) ? '0 : clk_cnt + 1'b1;
      if (rx_state == RX_START && tick)
        bit_idx <= '0;
      if (rx_state == RX_DATA && tick) begin
        rx_shift <= {rxd_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
      if (rx_state == RX_STOP && tick) begin
        if (rxd_sync) byte_vld  <= 1'b1;
        else          frame_err <= 1'b1;
      end
    end
  end

  assign len_full = {rx_shift, len_lo};
  assign word_end = (state == DATA) && byte_vld && (byte_cnt == 2'd3);

  always_comb begin
    state_n = state;
    if (frame_err) begin
      state_n = ERR;
    end else if (byte_vld) begin
      case (state)
        HDR:  if (rx_shift == 8'hA5) state_n = LEN0;
        LEN0: state_n = LEN1;
        LEN1: begin
          if ({1'b0, len_full} > MAX_WORDS) state_n = ERR;
          else if (len_full == 16'd0)       state_n = SUM;
          else                              state_n = DATA;
        end
        DATA: if (word_end && words_left == 16'd1) state_n = SUM;
        SUM:  state_n = (rx_shift == sum) ? DONE : ERR;
        DONE, ERR: if (rx_shift == 8'hA5) state_n = LEN0;
        default: state_n = HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HDR;
      len_lo        <= '0;
      words_left    <= '0;
      word_idx      <= '0;
      byte_cnt      <= '0;
      asm_word      <= '0;
      sum           <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      cpu_rst       <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state      <= state_n;
      mem.mem_we <= 1'b0;
      cpu_rst    <= (state_n != DONE);
      done       <= (state_n == DONE);
      err        <= (state_n == ERR);
      if (byte_vld) begin
        case (state)
          LEN0: len_lo <= rx_shift;
          LEN1: begin
            words_left <= len_full;
            word_idx   <= '0;
            byte_cnt   <= '0;
            sum        <= '0;
          end
          DATA: begin
            // Little-endian words: shift right so the first byte lands in bits [7:0].
            asm_word <= {rx_shift, asm_word[31:8]};
            sum      <= sum + rx_shift;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= word_idx;
              mem.mem_wdata <= {rx_shift, asm_word[31:8]};
              word_idx      <= word_idx + 1'b1;
              words_left    <= words_left - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
